// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller.
// Holds opcode values, control-bundle bit positions, ALUOp encodings and a
// helper that packs individual control fields into the 8-bit bundle.
package pipe_ctrl_pkg;

    // ID-stage opcodes
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    // Control bundle bit positions
    localparam int unsigned BitRegWrite = 0;
    localparam int unsigned BitMemToReg = 1;
    localparam int unsigned BitMemRead  = 2;
    localparam int unsigned BitMemWrite = 3;
    localparam int unsigned BitAluSrc   = 4;
    localparam int unsigned BitAluOpLo  = 5;
    localparam int unsigned BitRegDst   = 7;

    // ALUOp encodings
    localparam logic [1:0] AluOpAdd      = 2'b00;
    localparam logic [1:0] AluOpSub      = 2'b01;
    localparam logic [1:0] AluOpFunct    = 2'b10;
    localparam logic [1:0] AluOpLogicImm = 2'b11;

    function automatic logic [7:0] mk_ctrl(
        input logic       reg_dst,
        input logic [1:0] alu_op,
        input logic       alu_src,
        input logic       mem_write,
        input logic       mem_read,
        input logic       mem_to_reg,
        input logic       reg_write
    );
        logic [7:0] c;
        c                    = '0;
        c[BitRegDst]         = reg_dst;
        c[BitAluOpLo +: 2]   = alu_op;
        c[BitAluSrc]         = alu_src;
        c[BitMemWrite]       = mem_write;
        c[BitMemRead]        = mem_read;
        c[BitMemToReg]       = mem_to_reg;
        c[BitRegWrite]       = reg_write;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bus between the pipeline controller and its environment.
// ID-stage fields (op/rs/rt/rd/eq), the data-memory ready handshake, and all
// controller outputs (stage bundles, enables, redirects, stall counter).
// master: drives ID fields and dmem_ready_i; slave: the controller.
interface pipe_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       op_i;
    logic [REG_W-1:0] rs_i;
    logic [REG_W-1:0] rt_i;
    logic [REG_W-1:0] rd_i;
    logic             eq_i;
    logic             dmem_ready_i;

    logic [7:0]       ex_ctrl_o;
    logic [REG_W-1:0] ex_dest_o;
    logic [3:0]       mem_ctrl_o;
    logic [1:0]       wb_ctrl_o;
    logic [REG_W-1:0] wb_dest_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             branch_taken_o;
    logic             jump_o;
    logic             illegal_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output op_i, rs_i, rt_i, rd_i, eq_i, dmem_ready_i,
        input  ex_ctrl_o, ex_dest_o, mem_ctrl_o, wb_ctrl_o, wb_dest_o, pc_write_o,
               ifid_write_o, ifid_flush_o, branch_taken_o, jump_o, illegal_o, stall_cnt_o
    );

    modport slave (
        input  op_i, rs_i, rt_i, rd_i, eq_i, dmem_ready_i,
        output ex_ctrl_o, ex_dest_o, mem_ctrl_o, wb_ctrl_o, wb_dest_o, pc_write_o,
               ifid_write_o, ifid_flush_o, branch_taken_o, jump_o, illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// ctrl_decode: combinational ID-stage opcode decoder.
// Ports: op_i/rt_i/rd_i in; ctrl_o (8-bit bundle), dest_o (destination
// register, 0 when nothing is written), illegal_o, and per-opcode flags
// is_beq_o/is_bne_o/is_j_o for the redirect logic.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter bit          ENABLE_BNE = 1'b1
) (
    input  logic [5:0]       op_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] rd_i,
    output logic [7:0]       ctrl_o,
    output logic [REG_W-1:0] dest_o,
    output logic             illegal_o,
    output logic             is_beq_o,
    output logic             is_bne_o,
    output logic             is_j_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        is_beq_o  = 1'b0;
        is_bne_o  = 1'b0;
        is_j_o    = 1'b0;
        case (op_i)
            OpRType: ctrl_o = mk_ctrl(1'b1, AluOpFunct, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            OpAddi:  ctrl_o = mk_ctrl(1'b0, AluOpAdd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            OpAndi,
            OpOri:   ctrl_o = mk_ctrl(1'b0, AluOpLogicImm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            OpLw:    ctrl_o = mk_ctrl(1'b0, AluOpAdd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            OpSw:    ctrl_o = mk_ctrl(1'b0, AluOpAdd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OpBeq: begin
                ctrl_o   = mk_ctrl(1'b0, AluOpSub, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                is_beq_o = 1'b1;
            end
            OpBne: begin
                if (ENABLE_BNE) begin
                    ctrl_o   = mk_ctrl(1'b0, AluOpSub, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    is_bne_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OpJ:     is_j_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase

        // Non-writing instructions carry r0 so they never match a hazard check
        if (!ctrl_o[BitRegWrite]) begin
            dest_o = '0;
        end else if (ctrl_o[BitRegDst]) begin
            dest_o = rd_i;
        end else begin
            dest_o = rt_i;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control path of a 5-stage pipeline.
// Ports: clk_i, rst_i (synchronous, active-high), bus (pipe_ctrl_if.slave)
// carrying ID-stage fields, dmem_ready_i, the ID/EX, EX/MEM, MEM/WB bundles,
// PC/IF-ID enables, redirect outputs, illegal flag and saturating stall count.
// Stall priority: memory wait > load-use > branch/jump redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter bit          ENABLE_BNE = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input logic        clk_i,
    input logic        rst_i,
    pipe_ctrl_if.slave bus
);

    logic [7:0]       dec_ctrl;
    logic [REG_W-1:0] dec_dest;
    logic             dec_illegal;
    logic             is_beq;
    logic             is_bne;
    logic             is_j;

    logic [7:0]       ex_ctrl_q;
    logic [REG_W-1:0] ex_dest_q;
    logic [3:0]       mem_ctrl_q;
    logic [REG_W-1:0] mem_dest_q;
    logic [1:0]       wb_ctrl_q;
    logic [REG_W-1:0] wb_dest_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic mem_wait;
    logic stall;
    logic branch_taken;

    ctrl_decode #(
        .REG_W      (REG_W),
        .ENABLE_BNE (ENABLE_BNE)
    ) u_decode (
        .op_i      (bus.op_i),
        .rt_i      (bus.rt_i),
        .rd_i      (bus.rd_i),
        .ctrl_o    (dec_ctrl),
        .dest_o    (dec_dest),
        .illegal_o (dec_illegal),
        .is_beq_o  (is_beq),
        .is_bne_o  (is_bne),
        .is_j_o    (is_j)
    );

    always_comb begin
        load_use = ex_ctrl_q[BitMemRead] && (ex_dest_q != '0) &&
                   ((ex_dest_q == bus.rs_i) || (ex_dest_q == bus.rt_i));
        mem_wait = (mem_ctrl_q[3:2] != 2'b00) && !bus.dmem_ready_i;
        stall    = load_use || mem_wait;
        // Redirect is suppressed while stalled; the held ID instruction re-fires later
        branch_taken = !stall && ((is_beq && bus.eq_i) || (is_bne && !bus.eq_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl_q   <= '0;
            ex_dest_q   <= '0;
            mem_ctrl_q  <= '0;
            mem_dest_q  <= '0;
            wb_ctrl_q   <= '0;
            wb_dest_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (mem_wait) begin
                // ID/EX and EX/MEM hold; a bubble drains into WB
                wb_ctrl_q <= '0;
                wb_dest_q <= '0;
            end else begin
                if (load_use) begin
                    ex_ctrl_q <= '0;
                    ex_dest_q <= '0;
                end else begin
                    ex_ctrl_q <= dec_ctrl;
                    ex_dest_q <= dec_dest;
                end
                mem_ctrl_q <= ex_ctrl_q[3:0];
                mem_dest_q <= ex_dest_q;
                wb_ctrl_q  <= mem_ctrl_q[1:0];
                wb_dest_q  <= mem_dest_q;
            end
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.ex_ctrl_o      = ex_ctrl_q;
    assign bus.ex_dest_o      = ex_dest_q;
    assign bus.mem_ctrl_o     = mem_ctrl_q;
    assign bus.wb_ctrl_o      = wb_ctrl_q;
    assign bus.wb_dest_o      = wb_dest_q;
    assign bus.pc_write_o     = !stall;
    assign bus.ifid_write_o   = !stall;
    assign bus.branch_taken_o = branch_taken;
    assign bus.jump_o         = is_j && !stall;
    assign bus.ifid_flush_o   = branch_taken || (is_j && !stall);
    assign bus.illegal_o      = dec_illegal;
    assign bus.stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a directed vector table for decode/pipeline flow and
// load-use, plus hand sequences for memory wait, jump during wait, reset
// during stall, bne disabled and counter saturation (second instance).
module tb_pipe_ctrl;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ILL  = 6'b111111;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipe_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
    pipe_ctrl_if #(.REG_W(5), .CNT_W(2))  bus2 ();

    assign bus2.op_i         = bus.op_i;
    assign bus2.rs_i         = bus.rs_i;
    assign bus2.rt_i         = bus.rt_i;
    assign bus2.rd_i         = bus.rd_i;
    assign bus2.eq_i         = bus.eq_i;
    assign bus2.dmem_ready_i = bus.dmem_ready_i;

    pipe_ctrl #(.REG_W(5), .ENABLE_BNE(1'b1), .CNT_W(16)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    pipe_ctrl #(.REG_W(5), .ENABLE_BNE(1'b0), .CNT_W(2)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        eq;
        logic        rdy;
        logic [7:0]  ex;
        logic [3:0]  mem;
        logic [1:0]  wb;
        logic [4:0]  wbd;
        logic        pcw;
        logic        flush;
        logic        br;
        logic        j;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic eq, input logic rdy);
        bus.op_i         = op;
        bus.rs_i         = rs;
        bus.rt_i         = rt;
        bus.rd_i         = rd;
        bus.eq_i         = eq;
        bus.dmem_ready_i = rdy;
    endtask

    // From posedge+1: wait to the falling edge for sampling
    task automatic to_sample();
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(ILL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        drive(ILL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);

        //        op    rs rt rd eq rdy ex     mem   wb  wbd pcw fl br j  ill cnt
        tbl[0]  = '{ADDI, 1, 3, 0, 0, 1, 8'h00, 4'h0, 2'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{RT,   1, 2, 7, 0, 1, 8'h11, 4'h0, 2'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{ANDI, 0, 4, 0, 0, 1, 8'hC1, 4'h1, 2'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{ORI,  0, 6, 0, 0, 1, 8'h71, 4'h1, 2'd1, 3, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{BEQ,  1, 1, 0, 1, 1, 8'h71, 4'h1, 2'd1, 7, 1, 1, 1, 0, 0, 0};
        tbl[5]  = '{BNE,  1, 1, 0, 1, 1, 8'h20, 4'h1, 2'd1, 4, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{BNE,  1, 1, 0, 0, 1, 8'h20, 4'h0, 2'd1, 6, 1, 1, 1, 0, 0, 0};
        tbl[7]  = '{JMP,  0, 0, 0, 0, 1, 8'h20, 4'h0, 2'd0, 0, 1, 1, 0, 1, 0, 0};
        tbl[8]  = '{ILL,  0, 0, 0, 0, 1, 8'h00, 4'h0, 2'd0, 0, 1, 0, 0, 0, 1, 0};
        tbl[9]  = '{SW,   1, 9, 0, 0, 1, 8'h00, 4'h0, 2'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{LW,   1, 0, 0, 0, 1, 8'h18, 4'h0, 2'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{RT,   0, 0, 3, 0, 1, 8'h17, 4'h8, 2'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{LW,   1, 5, 0, 0, 1, 8'hC1, 4'h7, 2'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{RT,   5, 2, 8, 0, 1, 8'h17, 4'h1, 2'd3, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{RT,   5, 2, 8, 0, 1, 8'h00, 4'h7, 2'd1, 3, 1, 0, 0, 0, 0, 1};
        tbl[15] = '{ADDI, 0, 1, 0, 0, 1, 8'hC1, 4'h0, 2'd3, 5, 1, 0, 0, 0, 0, 1};

        // Reset state, with combinational outputs still live
        next_cycle();
        next_cycle();
        to_sample();
        chk("rst ex_ctrl", 32'(bus.ex_ctrl_o), 32'h00);
        chk("rst ex_dest", 32'(bus.ex_dest_o), 32'h0);
        chk("rst mem_ctrl", 32'(bus.mem_ctrl_o), 32'h0);
        chk("rst wb_ctrl", 32'(bus.wb_ctrl_o), 32'h0);
        chk("rst wb_dest", 32'(bus.wb_dest_o), 32'h0);
        chk("rst stall_cnt", 32'(bus.stall_cnt_o), 32'h0);
        chk("rst illegal", 32'(bus.illegal_o), 32'h1);
        chk("rst pc_write", 32'(bus.pc_write_o), 32'h1);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].eq, tbl[i].rdy);
            to_sample();
            chk($sformatf("row%0d ex_ctrl", i), 32'(bus.ex_ctrl_o), 32'(tbl[i].ex));
            chk($sformatf("row%0d mem_ctrl", i), 32'(bus.mem_ctrl_o), 32'(tbl[i].mem));
            chk($sformatf("row%0d wb_ctrl", i), 32'(bus.wb_ctrl_o), 32'(tbl[i].wb));
            chk($sformatf("row%0d wb_dest", i), 32'(bus.wb_dest_o), 32'(tbl[i].wbd));
            chk($sformatf("row%0d pc_write", i), 32'(bus.pc_write_o), 32'(tbl[i].pcw));
            chk($sformatf("row%0d ifid_write", i), 32'(bus.ifid_write_o), 32'(tbl[i].pcw));
            chk($sformatf("row%0d ifid_flush", i), 32'(bus.ifid_flush_o), 32'(tbl[i].flush));
            chk($sformatf("row%0d branch", i), 32'(bus.branch_taken_o), 32'(tbl[i].br));
            chk($sformatf("row%0d jump", i), 32'(bus.jump_o), 32'(tbl[i].j));
            chk($sformatf("row%0d illegal", i), 32'(bus.illegal_o), 32'(tbl[i].ill));
            chk($sformatf("row%0d stall_cnt", i), 32'(bus.stall_cnt_o), 32'(tbl[i].cnt));
            next_cycle();
        end

        // bne with the opcode disabled is illegal and never redirects
        drive(BNE, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1);
        to_sample();
        chk("bne_off illegal", 32'(bus2.illegal_o), 32'h1);
        chk("bne_off branch", 32'(bus2.branch_taken_o), 32'h0);
        chk("bne_on illegal", 32'(bus.illegal_o), 32'h0);
        next_cycle();

        // sw held in MEM for three cycles, jump arrives during the wait
        do_reset();
        drive(SW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        next_cycle();
        drive(ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        next_cycle();
        drive(JMP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            to_sample();
            chk($sformatf("wait%0d mem_ctrl", k), 32'(bus.mem_ctrl_o), 32'h8);
            chk($sformatf("wait%0d ex_ctrl", k), 32'(bus.ex_ctrl_o), 32'h11);
            chk($sformatf("wait%0d wb_ctrl", k), 32'(bus.wb_ctrl_o), 32'h0);
            chk($sformatf("wait%0d jump", k), 32'(bus.jump_o), 32'h0);
            chk($sformatf("wait%0d flush", k), 32'(bus.ifid_flush_o), 32'h0);
            chk($sformatf("wait%0d pc_write", k), 32'(bus.pc_write_o), 32'h0);
            chk($sformatf("wait%0d stall_cnt", k), 32'(bus.stall_cnt_o), 32'(k));
            next_cycle();
        end
        bus.dmem_ready_i = 1'b1;
        to_sample();
        chk("release stall_cnt", 32'(bus.stall_cnt_o), 32'd3);
        chk("release jump", 32'(bus.jump_o), 32'h1);
        chk("release flush", 32'(bus.ifid_flush_o), 32'h1);
        chk("release pc_write", 32'(bus.pc_write_o), 32'h1);
        chk("release wb_ctrl", 32'(bus.wb_ctrl_o), 32'h0);
        next_cycle();
        drive(ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        to_sample();
        chk("post mem_ctrl", 32'(bus.mem_ctrl_o), 32'h1);
        chk("post ex_ctrl", 32'(bus.ex_ctrl_o), 32'h00);
        chk("post jump", 32'(bus.jump_o), 32'h0);
        next_cycle();

        // Load-use and memory wait together for four cycles: counted once each
        do_reset();
        drive(SW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        next_cycle();
        drive(LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
        next_cycle();
        drive(RT, 5'd5, 5'd0, 5'd1, 1'b0, 1'b0);
        to_sample();
        chk("both pc_write", 32'(bus.pc_write_o), 32'h0);
        for (int k = 0; k < 4; k++) next_cycle();
        to_sample();
        chk("both stall_cnt", 32'(bus.stall_cnt_o), 32'd4);
        chk("sat stall_cnt", 32'(bus2.stall_cnt_o), 32'd3);
        chk("both ex_ctrl", 32'(bus.ex_ctrl_o), 32'h17);
        next_cycle();

        // Reset in the middle of a load-use stall
        do_reset();
        drive(LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
        next_cycle();
        drive(RT, 5'd5, 5'd2, 5'd8, 1'b0, 1'b1);
        to_sample();
        chk("lu pc_write", 32'(bus.pc_write_o), 32'h0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        to_sample();
        chk("lurst ex_ctrl", 32'(bus.ex_ctrl_o), 32'h0);
        chk("lurst ex_dest", 32'(bus.ex_dest_o), 32'h0);
        chk("lurst mem_ctrl", 32'(bus.mem_ctrl_o), 32'h0);
        chk("lurst wb_ctrl", 32'(bus.wb_ctrl_o), 32'h0);
        chk("lurst wb_dest", 32'(bus.wb_dest_o), 32'h0);
        chk("lurst stall_cnt", 32'(bus.stall_cnt_o), 32'h0);
        chk("lurst pc_write", 32'(bus.pc_write_o), 32'h1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-address width.
REQ-002 SHALL have parameter ENABLE_BNE, default 1, decodes opcode 000101 as bne when 1 and as illegal when 0.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 Ports (name  direction  width  meaning):
- clk_i  in  1  single clock; rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- op_i  in  6  ID-stage opcode.
- rs_i / rt_i / rd_i  in  REG_W each  ID-stage register fields.
- eq_i  in  1  ID-stage register compare, rs==rt.
- dmem_ready_i  in  1  data memory accepts or returns the MEM-stage access this cycle.
- ex_ctrl_o  out  8  ID/EX control bundle.
- ex_dest_o  out  REG_W  ID/EX destination register.
- mem_ctrl_o  out  4  EX/MEM bundle, bits [3:0].
- wb_ctrl_o  out  2  MEM/WB bundle, bits [1:0].
- wb_dest_o  out  REG_W  MEM/WB destination register.
- pc_write_o, ifid_write_o  out  1 each  PC and IF/ID enable.
- ifid_flush_o  out  1  clear IF/ID.
- branch_taken_o, jump_o  out  1 each  redirect PC.
- illegal_o  out  1  ID opcode is undecoded.
- stall_cnt_o  out  CNT_W  saturating stall-cycle count.

Function
REQ-005 Bundle bits SHALL be: [0] RegWrite, [1] MemtoReg, [2] MemRead, [3] MemWrite, [4] ALUSrc (1 = immediate), [6:5] ALUOp, [7] RegDst (1 = rd).
REQ-006 Decode SHALL be combinational in ID, with the following bundle values:
- R-type 000000 = 8'b1100_0001.
- addi 001000 = 8'b0001_0001.
- andi 001100 = 8'b0111_0001.
- ori 001101 = 8'b0111_0001.
- lw 100011 = 8'b0001_0111.
- sw 101011 = 8'b0001_1000.
- beq 000100 = 8'b0010_0000.
- bne 000101 = 8'b0010_0000.
- j 000010 = 8'h00.
- Any other opcode = 8'h00 with illegal_o=1.
REQ-007 Destination SHALL be rd_i when RegDst=1, else rt_i; it is forced to 0 when RegWrite=0.
REQ-008 Control SHALL shift one stage per cycle: ID->ex_ctrl_o, ex[3:0]->mem_ctrl_o, mem[1:0]->wb_ctrl_o, with destination carried alongside; latency ID to WB is 3 cycles.
REQ-009 Load-use SHALL be detected when all of the following hold: ex_ctrl_o[2]=1, ex_dest_o!=0, and ex_dest_o equals rs_i or rt_i.
- Response: pc_write_o=0 and ifid_write_o=0.
- A zero bundle and dest 0 are loaded into ID/EX next edge.
- EX/MEM and MEM/WB advance normally.
REQ-010 Memory wait SHALL occur when mem_ctrl_o[3:2]!=0 and dmem_ready_i=0.
- Response: ID/EX and EX/MEM hold.
- MEM/WB loads a zero bundle.
- pc_write_o=0, ifid_write_o=0.
REQ-011 branch_taken_o SHALL equal (beq & eq_i) | (bne & ~eq_i); jump_o SHALL equal (op_i==j); both are combinational.
REQ-012 ifid_flush_o SHALL equal branch_taken_o | jump_o.
REQ-013 Priority SHALL be memory wait > load-use > redirect.
- During either stall, branch_taken_o, jump_o and ifid_flush_o are forced to 0.
- The redirect re-evaluates once the stall clears.
REQ-014 With no stall, pc_write_o=1 and ifid_write_o=1.
REQ-015 stall_cnt_o SHALL increment on each cycle in which REQ-009 or REQ-010 holds, and SHALL saturate at all-ones.
REQ-016 Simultaneous load-use and memory wait SHALL count once per cycle.

Reset
REQ-017 On rst_i=1 at an edge, the following SHALL be zero: all pipeline bundles, all destinations, and stall_cnt_o.
REQ-018 Reset SHALL override a stall in progress; the first cycle after reset carries no stall unless caused by new ID inputs.
REQ-019 While rst_i=1, combinational outputs SHALL still follow REQ-006 to REQ-014 from the zeroed state.

Structure
REQ-020 Package pipe_ctrl_pkg SHALL hold:
- Opcode constants.
- Bundle bit-index constants.
- ALUOp encodings: 00 add, 01 sub, 10 funct, 11 logic-imm.
REQ-021 Combinational sub-module ctrl_decode SHALL implement REQ-006 and REQ-007; pipe_ctrl SHALL contain the pipeline registers, hazard logic and counter.

Verification
REQ-022 Issue lw rt=5 then R-type rs=5.
- Expected: one cycle with pc_write_o=0, ex_ctrl_o=8'h00 on the next cycle, stall_cnt_o=1.
REQ-023 Issue lw rt=0 then R-type rs=0.
- Expected: no stall, stall_cnt_o=0.
REQ-024 Issue sw reaching MEM with dmem_ready_i low for 3 cycles.
- Expected: mem_ctrl_o=4'b1000 held for 3 cycles, wb_ctrl_o=0, stall_cnt_o=3.
REQ-025 Drive beq with eq_i=1 (expect ifid_flush_o=1), then bne with eq_i=1.
- Expected for bne: branch_taken_o=0 with ENABLE_BNE=1; illegal_o=1 with ENABLE_BNE=0.
REQ-026 Drive j during a memory wait.
- Expected: jump_o=0 until dmem_ready_i=1, then jump_o=1 for one cycle.
REQ-027 Assert rst_i mid load-use stall.
- Expected: all registered outputs 0 next cycle.
- Also: with CNT_W=2 forced to 4 stalls, stall_cnt_o=3.
